r22_stage_ctrl: RTL and testbench

Sequencer for one radix-2² single-path delay-feedback (R2²SDF) FFT stage. It owns the stage sample counter and drives the BF2I/BF2II butterfly selects, the trivial −j multiply enable and the twiddle ROM address. It also frames stage output validity: fill latency, start-of-frame, and the end-of-burst flush with dummy samples. It sits beside each stage's butterfly datapath and is instantiated once per stage with a different `STAGE`.

---
 rtl/r22_pkg.sv | 39 +++
 rtl/r22_stage_ctrl_if.sv | 35 +++
 rtl/r22_tw_addr_gen.sv | 30 +++
 rtl/r22_stage_ctrl.sv | 142 ++++++++++++++
 tb/tb_r22_stage_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/r22_pkg.sv
// Shared definitions for the R2²SDF stage sequencer: state encoding,
// stage geometry helpers and the twiddle quadrant factor.
package r22_pkg;

  typedef enum logic [1:0] {
    R22_S_IDLE  = 2'd0,
    R22_S_RUN   = 2'd1,
    R22_S_FLUSH = 2'd2
  } r22_state_e;

  function automatic int r22_width(input int n_log, input int stage);
    return n_log - 2 * stage;
  endfunction

  function automatic int r22_period(input int n_log, input int stage);
    return 1 << r22_width(n_log, stage);
  endfunction

  function automatic int r22_l1(input int n_log, input int stage);
    return r22_period(n_log, stage) / 2;
  endfunction

  function automatic int r22_l2(input int n_log, input int stage);
    return r22_period(n_log, stage) / 4;
  endfunction

  // Quadrant q of the output index selects the twiddle exponent multiplier.
  function automatic logic [1:0] r22_quad_factor(input logic [1:0] q);
    logic [1:0] f;
    case (q)
      2'd0:    f = 2'd0;
      2'd1:    f = 2'd2;
      2'd2:    f = 2'd1;
      default: f = 2'd3;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/r22_stage_ctrl_if.sv
// Handshake and datapath-control bundle between an R2²SDF stage sequencer
// and its surroundings; slave is the sequencer side.
interface r22_stage_ctrl_if #(
  parameter int N_LOG = 6
);

  logic             i_valid;
  logic             i_sof;
  logic             i_flush;
  logic             i_ready;
  logic             o_ready;
  logic             o_adv;
  logic             o_inject;
  logic             o_bf1_sel;
  logic             o_bf2_sel;
  logic             o_negj;
  logic             o_out_valid;
  logic             o_out_sof;
  logic [N_LOG-1:0] o_tw_addr;
  logic             o_tw_valid;
  logic             o_err;

  modport master (
    output i_valid, i_sof, i_flush, i_ready,
    input  o_ready, o_adv, o_inject, o_bf1_sel, o_bf2_sel, o_negj,
           o_out_valid, o_out_sof, o_tw_addr, o_tw_valid, o_err
  );

  modport slave (
    input  i_valid, i_sof, i_flush, i_ready,
    output o_ready, o_adv, o_inject, o_bf1_sel, o_bf2_sel, o_negj,
           o_out_valid, o_out_sof, o_tw_addr, o_tw_valid, o_err
  );

endinterface

// File: rtl/r22_tw_addr_gen.sv
// Twiddle exponent for an R2²SDF stage: output index m -> (k * f(q)) << 2*STAGE,
// purely combinational.
module r22_tw_addr_gen
  import r22_pkg::*;
#(
  parameter int N_LOG = 6,
  parameter int STAGE = 0
) (
  input  logic [r22_width(N_LOG, STAGE)-1:0] m,
  output logic [N_LOG-1:0]                   tw_addr
);

  localparam int W = r22_width(N_LOG, STAGE);

  logic [N_LOG-1:0] k;
  logic [N_LOG-1:0] f;
  logic [N_LOG-1:0] prod;

  // The smallest stage has no k field, so its twiddle is always unity.
  if (W > 2) begin : g_k
    assign k = N_LOG'(m[W-3:0]);
  end else begin : g_k0
    assign k = '0;
  end

  assign f       = N_LOG'(r22_quad_factor(m[W-1:W-2]));
  assign prod    = k * f;
  assign tw_addr = prod << (2 * STAGE);

endmodule

// File: rtl/r22_stage_ctrl.sv
// Sequencer for one R2²SDF FFT stage: sample counter, butterfly selects, fill/flush
// framing and twiddle address. Define R22_STAGE_CTRL_TW_EN to build the twiddle generator.
module r22_stage_ctrl
  import r22_pkg::*;
#(
  parameter int N_LOG = 6,
  parameter int STAGE = 0
) (
  input logic              clk,
  input logic              reset,
  r22_stage_ctrl_if.slave  bus
);

  localparam int W = r22_width(N_LOG, STAGE);
  localparam int P = r22_period(N_LOG, STAGE);
  localparam int L2 = r22_l2(N_LOG, STAGE);
  localparam logic [W-1:0] FILL_MAX   = W'(3 * L2);
  localparam logic [W-1:0] DRAIN_LAST = W'(3 * L2 - 1);
  localparam logic [W-1:0] LAST_CNT   = W'(P - 1);
  localparam logic [W-1:0] CNT_ONE    = W'(1);

  r22_state_e   state, state_nxt;
  logic [W-1:0] cnt, cnt_nxt;
  logic [W-1:0] fill, fill_nxt;
  logic [W-1:0] drain, drain_nxt;
  logic [W-1:0] cur_cnt;
  logic [W-1:0] cur_fill;
  logic         ready;
  logic         acc;
  logic         adv;
  logic         inject;
  logic         err;
  logic         out_valid;

  // Holding reset also blocks acceptance so every output reads zero while held.
  assign ready = reset & bus.i_ready & (state != R22_S_FLUSH);
  assign acc   = bus.i_valid & ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= R22_S_IDLE;
      cnt   <= '0;
      fill  <= '0;
      drain <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      fill  <= fill_nxt;
      drain <= drain_nxt;
    end
  end

  // cur_cnt/cur_fill describe the sample shifted this cycle, after any (re)start.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fill_nxt  = fill;
    drain_nxt = drain;
    cur_cnt   = cnt;
    cur_fill  = fill;
    adv       = 1'b0;
    inject    = 1'b0;
    err       = 1'b0;
    unique case (state)
      R22_S_IDLE: begin
        cur_cnt  = '0;
        cur_fill = '0;
        if (acc) begin
          if (bus.i_sof) begin
            adv       = 1'b1;
            state_nxt = R22_S_RUN;
          end else begin
            err = 1'b1;
          end
        end
      end
      R22_S_RUN: begin
        adv = acc;
        if (acc && bus.i_sof && (cnt != '0)) begin
          cur_cnt  = '0;
          cur_fill = '0;
          err      = 1'b1;
        end
        if (acc && bus.i_flush && (cur_cnt == LAST_CNT)) begin
          state_nxt = R22_S_FLUSH;
          drain_nxt = '0;
        end
      end
      R22_S_FLUSH: begin
        adv    = bus.i_ready;
        inject = bus.i_ready;
        if (bus.i_ready) begin
          if (drain == DRAIN_LAST) begin
            state_nxt = R22_S_IDLE;
            drain_nxt = '0;
          end else begin
            drain_nxt = drain + CNT_ONE;
          end
        end
      end
      default: state_nxt = R22_S_IDLE;
    endcase
    if (adv) begin
      cnt_nxt  = cur_cnt + CNT_ONE;
      fill_nxt = (cur_fill == FILL_MAX) ? cur_fill : cur_fill + CNT_ONE;
    end
  end

  assign out_valid = adv & (cur_fill == FILL_MAX);

  assign bus.o_ready     = ready;
  assign bus.o_adv       = adv;
  assign bus.o_inject    = inject;
  assign bus.o_err       = err;
  assign bus.o_bf1_sel   = cur_cnt[W-1];
  assign bus.o_bf2_sel   = cur_cnt[W-2];
  assign bus.o_negj      = cur_cnt[W-1] & ~cur_cnt[W-2];
  assign bus.o_out_valid = out_valid;
  assign bus.o_out_sof   = out_valid & (cur_cnt == FILL_MAX);

`ifdef R22_STAGE_CTRL_TW_EN
  logic [W-1:0]     out_idx;
  logic [N_LOG-1:0] tw_addr;

  assign out_idx = cur_cnt - FILL_MAX;

  r22_tw_addr_gen #(
    .N_LOG (N_LOG),
    .STAGE (STAGE)
  ) u_tw_addr_gen (
    .m       (out_idx),
    .tw_addr (tw_addr)
  );

  assign bus.o_tw_addr  = tw_addr;
  assign bus.o_tw_valid = out_valid;
`else
  assign bus.o_tw_addr  = '0;
  assign bus.o_tw_valid = 1'b0;
`endif

endmodule

// File: tb/tb_r22_stage_ctrl.sv
// Bench for r22_stage_ctrl (N_LOG=4, STAGE=0): directed frames, flush, resync and
// async reset, then random traffic, all checked against a frame-position model.
module tb_r22_stage_ctrl;

  localparam int N_LOG = 4;
  localparam int STAGE = 0;
  localparam int P     = 1 << (N_LOG - 2 * STAGE);
  localparam int L2    = P / 4;
  localparam int LAT   = 3 * L2;
  localparam int VW    = 10 + N_LOG;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   quad_f [4] = '{0, 2, 1, 3};

  initial forever #5 clk = ~clk;

  r22_stage_ctrl_if #(.N_LOG(N_LOG)) bus ();

  r22_stage_ctrl #(
    .N_LOG (N_LOG),
    .STAGE (STAGE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst_v, input logic v, input logic s,
                               input logic f, input logic r);
    @(posedge clk);
    #1;
    reset       = rst_v;
    bus.i_valid = v;
    bus.i_sof   = s;
    bus.i_flush = f;
    bus.i_ready = r;
    @(negedge clk);
  endtask

  // Model state: mode 0/1/2 = idle/run/flush, n = advances since last (re)start.
  int   m_mode = 0;
  int   m_n = 0;
  int   m_drain = 0;
  int   idx, mi;
  logic e_ready, e_adv, e_inj, e_err, e_ov, e_osof, e_twv, e_b1, e_b2, e_nj, m_acc;
  logic [N_LOG-1:0] e_tw, tw_act;
  logic [VW-1:0] exp_vec, act_vec;

  initial begin
    forever begin
      @(negedge clk);
      {e_ready, e_adv, e_inj, e_err, e_ov, e_osof, e_twv, e_b1, e_b2, e_nj} = '0;
      e_tw = '0;
      idx  = 0;
      mi   = 0;
      if (!reset) begin
        m_mode  = 0;
        m_n     = 0;
        m_drain = 0;
      end else begin
        e_ready = (m_mode != 2) && bus.i_ready;
        m_acc   = bus.i_valid && e_ready;
        if (m_mode == 0) begin
          if (m_acc && bus.i_sof) begin
            e_adv = 1'b1;
            m_n   = 0;
          end else if (m_acc) begin
            e_err = 1'b1;
          end
        end else if (m_mode == 1) begin
          if (m_acc) begin
            e_adv = 1'b1;
            if (bus.i_sof && (m_n % P) != 0) begin
              e_err = 1'b1;
              m_n   = 0;
            end
          end
        end else begin
          e_adv = bus.i_ready;
          e_inj = bus.i_ready;
        end
        idx    = m_n % P;
        e_b1   = idx >= P / 2;
        e_b2   = (idx % (P / 2)) >= L2;
        e_nj   = (idx >= P / 2) && (idx < P / 2 + L2);
        e_ov   = e_adv && (m_n >= LAT);
        mi     = (idx - LAT + P) % P;
        e_osof = e_ov && (mi == 0);
      end
`ifdef R22_STAGE_CTRL_TW_EN
      e_twv  = e_ov;
      e_tw   = e_ov ? N_LOG'(((mi % L2) * quad_f[mi / L2]) << (2 * STAGE)) : '0;
      tw_act = e_ov ? bus.o_tw_addr : '0;
`else
      tw_act = bus.o_tw_addr;
`endif
      exp_vec = {e_ready, e_adv, e_inj, e_err, e_ov, e_osof, e_twv,
                 e_b1 & e_adv, e_b2 & e_adv, e_nj & e_adv, e_tw};
      act_vec = {bus.o_ready, bus.o_adv, bus.o_inject, bus.o_err, bus.o_out_valid,
                 bus.o_out_sof, bus.o_tw_valid, bus.o_bf1_sel & e_adv,
                 bus.o_bf2_sel & e_adv, bus.o_negj & e_adv, tw_act};
      checkOutput("cycle_outputs", 32'(act_vec), 32'(exp_vec));
      if (reset && e_adv) begin
        if (m_mode == 0) begin
          m_mode = 1;
        end else if (m_mode == 1 && bus.i_flush && idx == P - 1) begin
          m_mode  = 2;
          m_drain = 0;
        end else if (m_mode == 2) begin
          m_drain++;
          if (m_drain == LAT) m_mode = 0;
        end
        m_n++;
      end
    end
  end

  task automatic runCheckedFrame(input string tag);
    for (int s = 0; s < P; s++) begin
      applyStimulus(1'b1, 1'b1, (s == 0), 1'b0, 1'b1);
      if (s == 4)  checkOutput({tag, "_sel_s4"},  {bus.o_bf1_sel, bus.o_bf2_sel, bus.o_negj}, 3'b010);
      if (s == 8)  checkOutput({tag, "_sel_s8"},  {bus.o_bf1_sel, bus.o_bf2_sel, bus.o_negj}, 3'b101);
      if (s == 13) checkOutput({tag, "_sel_s13"}, {bus.o_bf1_sel, bus.o_bf2_sel, bus.o_negj}, 3'b110);
      if (s == 11) checkOutput({tag, "_valid_s11"}, bus.o_out_valid, 0);
      if (s == 12) checkOutput({tag, "_sof_s12"}, {bus.o_out_valid, bus.o_out_sof}, 2'b11);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish, want finish at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   cnt_v;
    int   done_cyc;
    int   tx;
    logic rst_v, v, s, f, r;

    bus.i_valid = 1'b1;
    bus.i_sof   = 1'b0;
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b1;

    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("reset_outputs",
                {bus.o_ready, bus.o_adv, bus.o_inject, bus.o_bf1_sel, bus.o_bf2_sel,
                 bus.o_negj, bus.o_out_valid, bus.o_out_sof, bus.o_tw_valid, bus.o_err,
                 bus.o_tw_addr}, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("idle_ready", bus.o_ready, 1);

    runCheckedFrame("frame1");

    // Back-to-back frame with flush requested on its last sample.
    for (int k = 0; k < P; k++) begin
      applyStimulus(1'b1, 1'b1, (k == 0), (k == P - 1), 1'b1);
`ifdef R22_STAGE_CTRL_TW_EN
      if (k == 1) checkOutput("tw_m5", bus.o_tw_addr, 2);
      if (k == 5) checkOutput("tw_m9", bus.o_tw_addr, 1);
      if (k == 9) checkOutput("tw_m13", bus.o_tw_addr, 3);
`else
      if (k == 5) checkOutput("tw_off", bus.o_tw_addr, 0);
`endif
    end
    cnt_v = 0;
    for (int k = 0; k < LAT; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      if (k == 0) checkOutput("flush_ready", bus.o_ready, 0);
      if (bus.o_inject && bus.o_out_valid) cnt_v++;
    end
    checkOutput("flush_drain_count", cnt_v, 12);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("idle_nosof", {bus.o_err, bus.o_adv, bus.o_ready}, 3'b101);

    // Flush with downstream ready toggling, starting low.
    for (int k = 0; k < P; k++) applyStimulus(1'b1, 1'b1, (k == 0), (k == P - 1), 1'b1);
    cnt_v    = 0;
    done_cyc = -1;
    for (int c = 1; c <= 60; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, (c % 2 == 0));
      if (bus.o_inject) cnt_v++;
      if (cnt_v == LAT) begin
        done_cyc = c;
        break;
      end
    end
    checkOutput("toggle_drain_cycles", done_cyc, 24);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("toggle_back_idle", bus.o_ready, 1);

    // Resync at cnt 5, then a resync coinciding with a flush request at cnt 15.
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b1, (k == 0), 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("resync_err", {bus.o_err, bus.o_adv, bus.o_out_valid}, 3'b110);
    cnt_v = 0;
    for (int j = 1; j < LAT; j++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      if (bus.o_out_valid) cnt_v++;
    end
    checkOutput("resync_fill_quiet", cnt_v, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("resync_first_out", {bus.o_out_valid, bus.o_out_sof}, 2'b11);
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("resync_flush_err", {bus.o_err, bus.o_adv}, 2'b11);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("resync_flush_stays_run", bus.o_ready, 1);

    // Async reset in the middle of a drain.
    for (int k = 2; k < P; k++) applyStimulus(1'b1, 1'b1, 1'b0, (k == P - 1), 1'b1);
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("middrain_inject", bus.o_inject, 1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_outputs",
                {bus.o_ready, bus.o_adv, bus.o_inject, bus.o_out_valid, bus.o_bf1_sel}, 0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    runCheckedFrame("after_reset");

    // Random traffic: sof mostly on frame boundaries, occasional glitches and resets.
    tx = 0;
    for (int c = 0; c < 3000; c++) begin
      rst_v = ($urandom_range(0, 399) != 0);
      v     = ($urandom_range(0, 3) != 0);
      s     = ((tx % P) == 0) || ($urandom_range(0, 63) == 0);
      f     = ($urandom_range(0, 7) == 0);
      r     = ($urandom_range(0, 7) != 0);
      applyStimulus(rst_v, v, s, f, r);
      if (!rst_v) tx = 0;
      else if (v && bus.o_ready) tx++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
